// File: rtl/axis_stream_checker.sv
// ----------------------------------------------------------------------------
// axis_stream_checker
//
// AXI4-Stream sink that checks every accepted beat against an incrementing
// data pattern, with packets of fixed length. A rising edge on start_read arms
// a run. Lowering start_read stops the run once the packet in flight has
// drained to its tlast. Counters and a first-error capture let a run be
// judged without a scoreboard.
//
// Ports
//   init_clk        in   clock, rising edge
//   s_axis_aresetn  in   asynchronous active-low reset
//   start_read      in   level request; rising edge arms, low requests stop
//   s_axis_tdata    in   stream data
//   s_axis_tvalid   in   stream valid
//   s_axis_tlast    in   end-of-packet marker
//   s_axis_tready   out  sink ready (registered, high while receiving)
//   busy            out  high while in RECV
//   done            out  one-cycle pulse after the RECV->IDLE transition
//   beat_cnt        out  accepted beats since arming (wraps)
//   pkt_cnt         out  accepted packets since arming (wraps)
//   err_cnt         out  erroring beats since arming (saturates)
//   err_flag        out  sticky, set on the first erroring beat
//   first_err_data  out  tdata of the first erroring beat
// ----------------------------------------------------------------------------
module axis_stream_checker #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    PKT_LEN    = 16,
    parameter logic [DATA_WIDTH-1:0] SEED       = '0
) (
    input  logic                  init_clk,
    input  logic                  s_axis_aresetn,
    input  logic                  start_read,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           beat_cnt,
    output logic [15:0]           pkt_cnt,
    output logic [15:0]           err_cnt,
    output logic                  err_flag,
    output logic [DATA_WIDTH-1:0] first_err_data
);

    localparam logic [15:0] LEN_16   = 16'(PKT_LEN);
    localparam logic [15:0] LAST_IDX = 16'(PKT_LEN - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_start_d;
    logic                  r_tready;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_exp_data;
    logic [15:0]           r_beat_idx;
    logic [15:0]           r_beat_cnt;
    logic [15:0]           r_pkt_cnt;
    logic [15:0]           r_err_cnt;
    logic                  r_err_flag;
    logic [DATA_WIDTH-1:0] r_first_err_data;

    logic w_accept;
    logic w_arm;
    logic w_stop;
    logic w_data_err;
    logic w_last_err;
    logic w_beat_err;

    // r_tready is high exactly while in RECV, so it doubles as the accept gate
    // and keeps tready free of any combinational path from tvalid/tdata.
    assign w_accept   = s_axis_tvalid & r_tready;
    assign w_data_err = (s_axis_tdata != r_exp_data);
    // Past the nominal last index every beat is wrong until a tlast arrives,
    // whether or not that beat carries tlast.
    assign w_last_err = (r_beat_idx >= LEN_16) |
                        (s_axis_tlast != (r_beat_idx == LAST_IDX));
    assign w_beat_err = w_accept & (w_data_err | w_last_err);

    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_arm        = 1'b0;
        w_stop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_read && !r_start_d) begin
                    w_next_state = RECV;
                    w_arm        = 1'b1;
                end
            end
            RECV: begin
                // Stop only at a packet boundary so a packet in flight drains.
                if (!start_read &&
                    (((r_beat_idx == 16'd0) && !w_accept) ||
                     (w_accept && s_axis_tlast))) begin
                    w_next_state = IDLE;
                    w_stop       = 1'b1;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge init_clk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            r_state   <= IDLE;
            r_start_d <= 1'b0;
            r_tready  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_start_d <= start_read;
            r_tready  <= (w_next_state == RECV);
            r_done    <= w_stop;
        end
    end

    always_ff @(posedge init_clk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            r_exp_data       <= SEED;
            r_beat_idx       <= '0;
            r_beat_cnt       <= '0;
            r_pkt_cnt        <= '0;
            r_err_cnt        <= '0;
            r_err_flag       <= 1'b0;
            r_first_err_data <= '0;
        end else if (w_arm) begin
            r_exp_data       <= SEED;
            r_beat_idx       <= '0;
            r_beat_cnt       <= '0;
            r_pkt_cnt        <= '0;
            r_err_cnt        <= '0;
            r_err_flag       <= 1'b0;
            r_first_err_data <= '0;
        end else if (w_accept) begin
            // The pattern keeps running on error; it is never resynchronised
            // to the received data.
            r_exp_data <= r_exp_data + 1'b1;
            r_beat_cnt <= r_beat_cnt + 16'd1;
            if (s_axis_tlast) begin
                r_beat_idx <= '0;
                r_pkt_cnt  <= r_pkt_cnt + 16'd1;
            end else begin
                r_beat_idx <= r_beat_idx + 16'd1;
            end
            if (w_beat_err) begin
                if (r_err_cnt != 16'hFFFF) begin
                    r_err_cnt <= r_err_cnt + 16'd1;
                end
                if (!r_err_flag) begin
                    r_err_flag       <= 1'b1;
                    r_first_err_data <= s_axis_tdata;
                end
            end
        end
    end

    assign s_axis_tready  = r_tready;
    assign busy           = (r_state == RECV);
    assign done           = r_done;
    assign beat_cnt       = r_beat_cnt;
    assign pkt_cnt        = r_pkt_cnt;
    assign err_cnt        = r_err_cnt;
    assign err_flag       = r_err_flag;
    assign first_err_data = r_first_err_data;

endmodule

// File: tb/tb_axis_stream_checker.sv
// ----------------------------------------------------------------------------
// tb_axis_stream_checker
//
// Directed bench for axis_stream_checker (DATA_WIDTH=32, PKT_LEN=16, SEED=0).
// A vector table covers arming, data and early-tlast errors, gaps, stop and
// an ignored re-arm. Hand-written sequences then cover an asynchronous reset
// mid-packet, a clean 4-packet run, a late tlast, backpressure gaps, and a
// stop requested mid-packet followed by a re-arm.
// ----------------------------------------------------------------------------
module tb_axis_stream_checker;

    logic        init_clk;
    logic        s_axis_aresetn;
    logic        start_read;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic        busy;
    logic        done;
    logic [15:0] beat_cnt;
    logic [15:0] pkt_cnt;
    logic [15:0] err_cnt;
    logic        err_flag;
    logic [31:0] first_err_data;

    int n_checks = 0;
    int n_errors = 0;

    axis_stream_checker #(
        .DATA_WIDTH (32),
        .PKT_LEN    (16),
        .SEED       (32'h0)
    ) dut (
        .init_clk       (init_clk),
        .s_axis_aresetn (s_axis_aresetn),
        .start_read     (start_read),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tready  (s_axis_tready),
        .busy           (busy),
        .done           (done),
        .beat_cnt       (beat_cnt),
        .pkt_cnt        (pkt_cnt),
        .err_cnt        (err_cnt),
        .err_flag       (err_flag),
        .first_err_data (first_err_data)
    );

    initial init_clk = 1'b0;
    always #5 init_clk = ~init_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        start;
        logic        valid;
        logic [31:0] data;
        logic        last;
        logic        e_rdy;
        logic        e_done;
        logic [15:0] e_beat;
        logic [15:0] e_pkt;
        logic [15:0] e_err;
        logic        e_flag;
        logic [31:0] e_fed;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Apply one cycle of stimulus, then sample 1 ns after the rising edge.
    task automatic beat(input logic [31:0] d, input logic l, input logic v, input logic s);
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = v;
        start_read    = s;
        @(posedge init_clk);
        #1;
    endtask

    task automatic arm();
        beat(32'h0, 1'b0, 1'b0, 1'b1);
        check("arm_tready", 32'(s_axis_tready), 1);
        check("arm_busy",   32'(busy), 1);
        check("arm_beats",  32'(beat_cnt), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tready"}, 32'(s_axis_tready), 0);
        check({tag, "_busy"},   32'(busy), 0);
        check({tag, "_done"},   32'(done), 0);
        check({tag, "_beat"},   32'(beat_cnt), 0);
        check({tag, "_pkt"},    32'(pkt_cnt), 0);
        check({tag, "_err"},    32'(err_cnt), 0);
        check({tag, "_flag"},   32'(err_flag), 0);
        check({tag, "_fed"},    first_err_data, 0);
    endtask

    initial begin
        int n_done;

        //              st  v   data          l   rdy dn beat pkt err fl fed
        vecs[0]  = '{1'b1, 1'b0, 32'h0,      1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b1, 32'h0,      1'b0, 1'b1, 1'b0, 16'd1, 16'd0, 16'd0, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 1'b1, 32'h1,      1'b0, 1'b1, 1'b0, 16'd2, 16'd0, 16'd0, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 1'b1, 32'hDEAD,   1'b0, 1'b1, 1'b0, 16'd3, 16'd0, 16'd1, 1'b1, 32'hDEAD};
        vecs[4]  = '{1'b1, 1'b1, 32'h3,      1'b0, 1'b1, 1'b0, 16'd4, 16'd0, 16'd1, 1'b1, 32'hDEAD};
        vecs[5]  = '{1'b1, 1'b0, 32'h99,     1'b1, 1'b1, 1'b0, 16'd4, 16'd0, 16'd1, 1'b1, 32'hDEAD};
        vecs[6]  = '{1'b1, 1'b1, 32'h4,      1'b1, 1'b1, 1'b0, 16'd5, 16'd1, 16'd2, 1'b1, 32'hDEAD};
        vecs[7]  = '{1'b0, 1'b1, 32'h5,      1'b0, 1'b1, 1'b0, 16'd6, 16'd1, 16'd2, 1'b1, 32'hDEAD};
        vecs[8]  = '{1'b0, 1'b1, 32'h6,      1'b1, 1'b0, 1'b1, 16'd7, 16'd2, 16'd3, 1'b1, 32'hDEAD};
        vecs[9]  = '{1'b0, 1'b1, 32'h7,      1'b0, 1'b0, 1'b0, 16'd7, 16'd2, 16'd3, 1'b1, 32'hDEAD};
        vecs[10] = '{1'b1, 1'b0, 32'h0,      1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 1'b1, 32'h0,      1'b0, 1'b1, 1'b0, 16'd1, 16'd0, 16'd0, 1'b0, 32'h0};
        vecs[12] = '{1'b1, 1'b1, 32'h1,      1'b0, 1'b1, 1'b0, 16'd2, 16'd0, 16'd0, 1'b0, 32'h0};
        vecs[13] = '{1'b0, 1'b0, 32'h0,      1'b0, 1'b1, 1'b0, 16'd2, 16'd0, 16'd0, 1'b0, 32'h0};
        vecs[14] = '{1'b1, 1'b1, 32'h2,      1'b0, 1'b1, 1'b0, 16'd3, 16'd0, 16'd0, 1'b0, 32'h0};

        // Reset state.
        s_axis_aresetn = 1'b0;
        start_read     = 1'b0;
        s_axis_tdata   = '0;
        s_axis_tvalid  = 1'b0;
        s_axis_tlast   = 1'b0;
        repeat (2) @(posedge init_clk);
        #1;
        check_all_zero("reset");
        @(negedge init_clk);
        s_axis_aresetn = 1'b1;
        beat(32'h0, 1'b0, 1'b1, 1'b0);
        check("idle_tready", 32'(s_axis_tready), 0);
        check("idle_no_accept", 32'(beat_cnt), 0);

        // Vector table: arm, data error, gap, early tlast, stop, re-arm,
        // pause without stopping, and a rising start_read ignored in RECV.
        for (int i = 0; i < 15; i++) begin
            beat(vecs[i].data, vecs[i].last, vecs[i].valid, vecs[i].start);
            check($sformatf("vec%0d_tready", i), 32'(s_axis_tready), 32'(vecs[i].e_rdy));
            check($sformatf("vec%0d_busy", i),   32'(busy),          32'(vecs[i].e_rdy));
            check($sformatf("vec%0d_done", i),   32'(done),          32'(vecs[i].e_done));
            check($sformatf("vec%0d_beat", i),   32'(beat_cnt),      32'(vecs[i].e_beat));
            check($sformatf("vec%0d_pkt", i),    32'(pkt_cnt),       32'(vecs[i].e_pkt));
            check($sformatf("vec%0d_err", i),    32'(err_cnt),       32'(vecs[i].e_err));
            check($sformatf("vec%0d_flag", i),   32'(err_flag),      32'(vecs[i].e_flag));
            check($sformatf("vec%0d_fed", i),    first_err_data,     vecs[i].e_fed);
        end

        // Asynchronous reset at beat 3, between clock edges.
        #2;
        s_axis_aresetn = 1'b0;
        start_read     = 1'b0;
        s_axis_tvalid  = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge init_clk);
        s_axis_aresetn = 1'b1;
        repeat (2) begin
            beat(32'h0, 1'b0, 1'b1, 1'b0);
            check("post_rst_tready", 32'(s_axis_tready), 0);
            check("post_rst_beat", 32'(beat_cnt), 0);
        end

        // Clean run: 4 packets of 0..63, start_read dropped with the last tlast.
        arm();
        n_done = 0;
        for (int i = 0; i < 64; i++) begin
            beat(32'(i), (i % 16) == 15, 1'b1, i != 63);
            if (done) n_done++;
        end
        check("clean_beat", 32'(beat_cnt), 64);
        check("clean_pkt", 32'(pkt_cnt), 4);
        check("clean_err", 32'(err_cnt), 0);
        check("clean_flag", 32'(err_flag), 0);
        check("clean_done_now", 32'(done), 1);
        check("clean_tready_low", 32'(s_axis_tready), 0);
        repeat (3) begin
            beat(32'h0, 1'b0, 1'b1, 1'b0);
            if (done) n_done++;
        end
        check("clean_done_pulses", 32'(n_done), 1);
        check("clean_tready_idle", 32'(s_axis_tready), 0);

        // Late tlast: 20-beat packet; indices 15..19 are last errors.
        arm();
        for (int i = 0; i < 20; i++) begin
            beat(32'(i), i == 19, 1'b1, i != 19);
            if (i == 14) check("late_err_before", 32'(err_cnt), 0);
            if (i == 15) check("late_err_at15", 32'(err_cnt), 1);
        end
        check("late_err", 32'(err_cnt), 5);
        check("late_pkt", 32'(pkt_cnt), 1);
        check("late_beat", 32'(beat_cnt), 20);
        check("late_fed", first_err_data, 32'd15);
        check("late_done", 32'(done), 1);

        // Backpressure: random gaps with garbage data and tlast on idle cycles.
        arm();
        for (int i = 0; i < 48; i++) begin
            repeat ($urandom_range(0, 2)) begin
                beat(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
                check("gap_no_accept", 32'(beat_cnt), 32'(i));
            end
            beat(32'(i), (i % 16) == 15, 1'b1, i != 47);
        end
        check("bp_beat", 32'(beat_cnt), 48);
        check("bp_pkt", 32'(pkt_cnt), 3);
        check("bp_err", 32'(err_cnt), 0);
        check("bp_done", 32'(done), 1);

        // Stop requested at beat 7: the packet drains to its tlast.
        arm();
        for (int i = 0; i < 16; i++) begin
            check("mid_tready", 32'(s_axis_tready), 1);
            beat(32'(i), i == 15, 1'b1, i < 7);
        end
        check("mid_done", 32'(done), 1);
        check("mid_tready_low", 32'(s_axis_tready), 0);
        check("mid_pkt", 32'(pkt_cnt), 1);
        check("mid_beat", 32'(beat_cnt), 16);
        check("mid_err", 32'(err_cnt), 0);
        beat(32'h0, 1'b0, 1'b0, 1'b0);
        check("mid_done_clear", 32'(done), 0);

        // Re-arm clears counters and restarts the pattern at SEED.
        arm();
        check("rearm_pkt", 32'(pkt_cnt), 0);
        beat(32'h0, 1'b0, 1'b1, 1'b1);
        check("rearm_seed_err", 32'(err_cnt), 0);
        check("rearm_beat", 32'(beat_cnt), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axis_stream_checker.md
# axis_stream_checker

AXI4-Stream sink that consumes the master side of the stream FIFO under test and checks it, beat by beat, against an incrementing data pattern with fixed-length packets.
- Arming and draining are gated by the `start_read` control used at `top`.
- Exposes beat, packet and error counters plus a first-error capture so the testbench and ILA can judge a write/read run without a scoreboard.

## Interface
- `DATA_WIDTH`, 32: width of `s_axis_tdata`.
- `PKT_LEN`, 16: beats per packet; legal range 1..65535.
- `SEED`, 0: expected `tdata` of the first beat after arming.

- `init_clk`  in  1  sole clock; all logic rises on this edge.
- `s_axis_aresetn`  in  1  asynchronous, active-low reset; deassertion is synchronous to `init_clk` at system level.
- `start_read`  in  1  level request; its rising edge arms a run, and low requests stop.
- `s_axis_tdata`  in  DATA_WIDTH  stream data.
- `s_axis_tvalid`  in  1  stream valid.
- `s_axis_tlast`  in  1  end-of-packet marker.
- `s_axis_tready`  out  1  sink ready; registered.
- `busy`  out  1  high while in state RECV.
- `done`  out  1  one-cycle pulse on the RECV->IDLE transition.
- `beat_cnt`  out  16  accepted beats since arming; wraps at 2^16.
- `pkt_cnt`  out  16  accepted packets since arming; wraps at 2^16.
- `err_cnt`  out  16  erroring beats since arming; saturates at 0xFFFF.
- `err_flag`  out  1  sticky; set on the first erroring beat.
- `first_err_data`  out  DATA_WIDTH  `tdata` of the first erroring beat.

## Operation
- **Beat acceptance:** a beat is accepted when `s_axis_tvalid & s_axis_tready` at a rising edge. No other input is sampled as a beat.
- **Registered internal state:**
  - `start_d`: `start_read` delayed one cycle.
  - `exp_data` (DATA_WIDTH bits).
  - `beat_idx` (16 bits): position within the current packet.
  - `state`: IDLE or RECV.
- **IDLE:**
  - `s_axis_tready`=0.
  - On `start_read & ~start_d`, go to RECV and arm:
    - `exp_data`=SEED, `beat_idx`=0;
    - `beat_cnt`, `pkt_cnt`, `err_cnt`, `err_flag`, `first_err_data` all cleared to 0.
- **RECV:**
  - `s_axis_tready`=1.
  - On each accepted beat:
    - Data error if `tdata != exp_data`.
    - Last error if `tlast != (beat_idx == PKT_LEN-1)`.
    - Either error, or both together, counts as one erroring beat: `err_cnt`+1 (saturating).
    - If `err_flag` was 0, set `err_flag` and capture `first_err_data`.
    - `exp_data` <= `exp_data`+1, modulo 2^DATA_WIDTH. This applies even on error: the pattern continues across packets and is not resynchronised to the received `tdata`.
    - `beat_cnt`+1.
    - If `tlast`=1: `beat_idx`<=0 and `pkt_cnt`+1, including an early or unexpected `tlast`. Otherwise `beat_idx`+1.
    - Beat with `tlast`=0 at `beat_idx`=PKT_LEN-1: flag a last error and continue at `beat_idx`=PKT_LEN, counting up. Every later beat is a last error until a `tlast` is accepted.
- **Stop:**
  - Go RECV->IDLE when `start_read`=0 and either:
    - `beat_idx`=0 with no beat accepted this cycle, or
    - a beat with `tlast`=1 is accepted this cycle.
  - A packet in flight is therefore always drained to its `tlast`.
  - `done`=1 for exactly the cycle after the transition edge.
- **Re-arm:** a `start_read` rising edge while in RECV is ignored. Re-arming needs IDLE plus a new rising edge.
- **Reset:** asynchronous assertion at any point, mid-packet included, forces:
  - state=IDLE, `start_d`=0;
  - all counters, `err_flag` and `first_err_data` = 0;
  - `s_axis_tready`, `busy`, `done` = 0.
  - No partial packet is counted.

## Timing
- **Arm latency:** `start_read` is sampled high at edge N with `start_d`=0. After edge N, state=RECV and `s_axis_tready`=`busy`=1. The first beat can be accepted at edge N+1.
- **Throughput:** one beat per cycle with no bubbles while `tvalid` is held. `s_axis_tready` never depends combinationally on `tvalid` or `tdata`.
- **Output update:** counters and flags update at the accept edge and are visible in the following cycle.
- **Stop latency:** the stop condition is true at edge M. After edge M, `s_axis_tready`=0 and `done`=1. `done` returns to 0 after edge M+1.
- **Stop vs accept on the same edge:** if `start_read` falls on the same edge that a mid-packet beat is accepted, that beat is fully checked and counted, and reception continues.

## Test plan
- **Clean run:** PKT_LEN=16, SEED=0. Arm, then drive 4 packets of `tdata` 0..63 with `tlast` on every 16th beat; drop `start_read` after the last `tlast`.
  -> `beat_cnt`=64, `pkt_cnt`=4, `err_cnt`=0, one `done` pulse, `tready` low after it.
- **Data corruption:** send beat 5 as 0xDEAD instead of 5, all else clean for 2 packets.
  -> `err_cnt`=1, `err_flag`=1, `first_err_data`=0xDEAD; beat 6 (value 6) passes.
- **Early and late `tlast`:** `tlast` on beat index 9, then on a 20-beat packet.
  -> Early `tlast`: `err_cnt`+1 and `pkt_cnt`+1 at the early `tlast`.
  -> Late packet: last errors on indices 15..19, i.e. 5 errors, then `pkt_cnt`+1.
- **Backpressure and gaps:** `tvalid` toggled 1,0,0,1 pseudo-randomly over 3 packets.
  -> Zero errors, `beat_cnt`=48; no beat accepted while `tvalid`=0.
- **Stop mid-packet:** drop `start_read` at beat 7 of a packet.
  -> `tready` stays 1 through beat 15 with `tlast`, `done` the next cycle, `pkt_cnt` includes that packet.
  -> Re-raise `start_read`: counters cleared, `exp_data`=SEED.
- **Reset mid-packet:** assert `s_axis_aresetn`=0 at beat 3, asynchronously between edges.
  -> All outputs 0 immediately; after release, IDLE and `tready`=0 until a new `start_read` rising edge.
